onewire_byte_reader: RTL



---
 rtl/onewire_pkg.sv | 20 ++
 rtl/onewire_bus_sync.sv | 25 ++
 rtl/onewire_byte_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-Wire constants: slot timing, command bytes and the read-FSM state encoding.
package onewire_pkg;

  localparam int SLOT_TICKS     = 60;
  localparam int INIT_LOW_TICKS = 2;
  localparam int SAMPLE_TICK    = 13;
  localparam int RECOVERY_TICKS = 11;

  localparam logic [7:0] SKIP_ROM        = 8'hCC;
  localparam logic [7:0] CONVERT_T       = 8'h44;
  localparam logic [7:0] READ_SCRATCHPAD = 8'hBE;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_SLOT    = 2'd1,
    RD_RECOVER = 2'd2,
    RD_DONE    = 2'd3
  } rd_state_e;

endpackage

// File: rtl/onewire_bus_sync.sv
// Two-flop synchronizer for the sensed 1-Wire line; resets to the idle (released, high) level.
module onewire_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic bus,
  output logic bus_s
);

  logic meta_r;
  logic sync_r;

  // Double-register the asynchronous bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= bus;
      sync_r <= meta_r;
    end
  end

  assign bus_s = sync_r;

endmodule

// File: rtl/onewire_byte_reader.sv
// Generates eight 1-Wire master read slots and assembles the sampled reply LSB-first into a byte.
module onewire_byte_reader #(
  parameter int SLOT_TICKS     = onewire_pkg::SLOT_TICKS,
  parameter int INIT_LOW_TICKS = onewire_pkg::INIT_LOW_TICKS,
  parameter int SAMPLE_TICK    = onewire_pkg::SAMPLE_TICK,
  parameter int RECOVERY_TICKS = onewire_pkg::RECOVERY_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_byte_reader,
  input  logic       bus,
  output logic       master_pull_low,
  output logic [7:0] data_out,
  output logic       done_byte_reading
);

  import onewire_pkg::*;

  localparam int SLOT_W = $clog2(SLOT_TICKS);
  localparam int REC_W  = $clog2(RECOVERY_TICKS);

  localparam logic [SLOT_W-1:0] SLOT_LAST_C = SLOT_W'(SLOT_TICKS - 1);
  localparam logic [SLOT_W-1:0] SAMPLE_C    = SLOT_W'(SAMPLE_TICK);
  localparam logic [SLOT_W-1:0] INIT_LOW_C  = SLOT_W'(INIT_LOW_TICKS);
  localparam logic [REC_W-1:0]  REC_LAST_C  = REC_W'(RECOVERY_TICKS - 1);

  localparam logic [1:0] ST_IDLE    = RD_IDLE;
  localparam logic [1:0] ST_SLOT    = RD_SLOT;
  localparam logic [1:0] ST_RECOVER = RD_RECOVER;
  localparam logic [1:0] ST_DONE    = RD_DONE;

  logic              bus_s;
  logic [1:0]        state_r, state_nxt_s;
  logic [SLOT_W-1:0] slot_cnt_r, slot_cnt_nxt_s;
  logic [REC_W-1:0]  rec_cnt_r, rec_cnt_nxt_s;
  logic [2:0]        bit_idx_r, bit_idx_nxt_s;
  logic [7:0]        shift_reg_r, shift_nxt_s;
  logic [7:0]        data_out_r, data_nxt_s;
  logic              pull_low_r, pull_low_nxt_s;
  logic              done_r, done_nxt_s;

  onewire_bus_sync u_bus_sync (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .bus_s (bus_s)
  );

  // Slot sequencer: next state, counters, bit capture and registered-output decode
  always_comb begin
    state_nxt_s    = state_r;
    slot_cnt_nxt_s = slot_cnt_r;
    rec_cnt_nxt_s  = rec_cnt_r;
    bit_idx_nxt_s  = bit_idx_r;
    shift_nxt_s    = shift_reg_r;
    case (state_r)
      ST_IDLE: begin
        if (en_byte_reader) begin
          state_nxt_s    = ST_SLOT;
          slot_cnt_nxt_s = {SLOT_W{1'b0}};
          bit_idx_nxt_s  = 3'd0;
          shift_nxt_s    = 8'h00;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SLOT: begin
        if (!en_byte_reader) begin
          state_nxt_s = ST_IDLE;
        end else begin
          if (slot_cnt_r == SAMPLE_C) begin
            shift_nxt_s[bit_idx_r] = bus_s;
          end else begin
            shift_nxt_s = shift_reg_r;
          end
          if (slot_cnt_r == SLOT_LAST_C) begin
            state_nxt_s   = ST_RECOVER;
            rec_cnt_nxt_s = {REC_W{1'b0}};
          end else begin
            slot_cnt_nxt_s = slot_cnt_r + 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        if (!en_byte_reader) begin
          state_nxt_s = ST_IDLE;
        end else if (rec_cnt_r == REC_LAST_C) begin
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s    = ST_SLOT;
            bit_idx_nxt_s  = bit_idx_r + 3'd1;
            slot_cnt_nxt_s = {SLOT_W{1'b0}};
          end
        end else begin
          rec_cnt_nxt_s = rec_cnt_r + 1'b1;
        end
      end
      ST_DONE: begin
        if (!en_byte_reader) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered
    pull_low_nxt_s = (state_nxt_s == ST_SLOT) && (slot_cnt_nxt_s < INIT_LOW_C);
    done_nxt_s     = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
    if (done_nxt_s) begin
      data_nxt_s = shift_reg_r;
    end else begin
      data_nxt_s = data_out_r;
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      slot_cnt_r  <= {SLOT_W{1'b0}};
      rec_cnt_r   <= {REC_W{1'b0}};
      bit_idx_r   <= 3'd0;
      shift_reg_r <= 8'h00;
      data_out_r  <= 8'h00;
      pull_low_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      slot_cnt_r  <= slot_cnt_nxt_s;
      rec_cnt_r   <= rec_cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      shift_reg_r <= shift_nxt_s;
      data_out_r  <= data_nxt_s;
      pull_low_r  <= pull_low_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign master_pull_low   = pull_low_r;
  assign data_out          = data_out_r;
  assign done_byte_reading = done_r;

endmodule
